sram_unit_access_ctrl: RTL and testbench

//  Sequences one SRAM unit access (read or masked sub-word write) from a valid/ready request port.

---
 rtl/sram_unit_access_ctrl.sv | 222 ++++++++++++++++++++++
 tb/tb_sram_unit_access_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/sram_unit_access_ctrl.sv
// sram_unit_access_ctrl: sequences one SRAM unit access (read or masked
// sub-word write) from a valid/ready request port.
//
// Ports
//   clk, reset (async, active-high)
//   req_valid/req_ready/req_we/req_size/req_addr/req_wdata : request port
//   resp_valid/resp_ready/resp_rdata                       : response port
//   resp_err (only with SRAM_ALIGN_CHECK_EN)               : misaligned request
//   sram_row, unit_3_8_dec_sel, c8/c4/c2/c1                : address and mask to the unit
//   precharge, wl_en, we, sae                              : phase strobes
//   sram_wdata / sram_rdata                                : lane-aligned data to/from the unit
//
// Configuration macro: SRAM_ALIGN_CHECK_EN
//   When defined, a request whose bit index is not a multiple of its width
//   goes straight to the response with resp_err=1 and no strobes.
//   When undefined, low index bits below the width are dropped.
module sram_unit_access_ctrl #(
    parameter int unsigned ROW_W      = 4,
    parameter int unsigned PRE_CYCLES = 1,
    parameter int unsigned WL_CYCLES  = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [1:0]       req_size,
    input  logic [ROW_W+2:0] req_addr,
    input  logic [7:0]       req_wdata,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [7:0]       resp_rdata,
`ifdef SRAM_ALIGN_CHECK_EN
    output logic             resp_err,
`endif
    output logic [ROW_W-1:0] sram_row,
    output logic [2:0]       unit_3_8_dec_sel,
    output logic             c8,
    output logic             c4,
    output logic             c2,
    output logic             c1,
    output logic             precharge,
    output logic             wl_en,
    output logic             we,
    output logic             sae,
    output logic [7:0]       sram_wdata,
    input  logic [7:0]       sram_rdata
);

    localparam int unsigned MAX_CYC = (PRE_CYCLES > WL_CYCLES) ? PRE_CYCLES : WL_CYCLES;
    localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PRE   = 3'd1,
        ACC   = 3'd2,
        SENSE = 3'd3,
        RESP  = 3'd4
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             we_q;
    logic [7:0]       mask_q;
    logic [2:0]       off_q;

    logic [2:0]       sel_c;
    logic [2:0]       off_c;
    logic [7:0]       mask_c;
    logic [3:0]       code_c;

    // Request decode: sub-word index, lane bit offset, field mask, width code.
    // The lane offset equals the bit index with the bits below the width cleared.
    always_comb begin
        sel_c  = 3'd0;
        off_c  = 3'd0;
        mask_c = 8'h00;
        code_c = 4'b0000;
        case (req_size)
            2'd0: begin
                sel_c  = req_addr[2:0];
                off_c  = req_addr[2:0];
                mask_c = 8'h01;
                code_c = 4'b0001;
            end
            2'd1: begin
                sel_c  = {1'b0, req_addr[2:1]};
                off_c  = {req_addr[2:1], 1'b0};
                mask_c = 8'h03;
                code_c = 4'b0010;
            end
            2'd2: begin
                sel_c  = {2'b00, req_addr[2]};
                off_c  = {req_addr[2], 2'b00};
                mask_c = 8'h0F;
                code_c = 4'b0100;
            end
            default: begin
                sel_c  = 3'd0;
                off_c  = 3'd0;
                mask_c = 8'hFF;
                code_c = 4'b1000;
            end
        endcase
    end

`ifdef SRAM_ALIGN_CHECK_EN
    logic mis_c;
    // Only 2b and 4b accesses can be misaligned; 8b ignores the index.
    assign mis_c = ((req_size == 2'd1) && req_addr[0]) ||
                   ((req_size == 2'd2) && (req_addr[1:0] != 2'b00));
`endif

    // Access sequencer; every output is registered and updated with the state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= IDLE;
            cnt              <= '0;
            we_q             <= 1'b0;
            mask_q           <= 8'h00;
            off_q            <= 3'd0;
            req_ready        <= 1'b1;
            resp_valid       <= 1'b0;
            resp_rdata       <= 8'h00;
`ifdef SRAM_ALIGN_CHECK_EN
            resp_err         <= 1'b0;
`endif
            sram_row         <= '0;
            unit_3_8_dec_sel <= 3'd0;
            {c8, c4, c2, c1} <= 4'b0000;
            precharge        <= 1'b0;
            wl_en            <= 1'b0;
            we               <= 1'b0;
            sae              <= 1'b0;
            sram_wdata       <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        we_q             <= req_we;
                        mask_q           <= mask_c;
                        off_q            <= off_c;
                        req_ready        <= 1'b0;
                        sram_row         <= req_addr[ROW_W+2:3];
                        unit_3_8_dec_sel <= sel_c;
                        sram_wdata       <= 8'((req_wdata & mask_c) << off_c);
`ifdef SRAM_ALIGN_CHECK_EN
                        if (mis_c) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= 8'h00;
                        end else begin
                            state            <= PRE;
                            precharge        <= 1'b1;
                            {c8, c4, c2, c1} <= code_c;
                            cnt              <= CNT_W'(PRE_CYCLES - 1);
                        end
`else
                        state            <= PRE;
                        precharge        <= 1'b1;
                        {c8, c4, c2, c1} <= code_c;
                        cnt              <= CNT_W'(PRE_CYCLES - 1);
`endif
                    end
                end
                PRE: begin
                    if (cnt == '0) begin
                        state     <= ACC;
                        precharge <= 1'b0;
                        wl_en     <= 1'b1;
                        we        <= we_q;
                        cnt       <= CNT_W'(WL_CYCLES - 1);
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ACC: begin
                    if (cnt == '0) begin
                        if (we_q) begin
                            state            <= RESP;
                            wl_en            <= 1'b0;
                            we               <= 1'b0;
                            {c8, c4, c2, c1} <= 4'b0000;
                            resp_valid       <= 1'b1;
                            resp_rdata       <= 8'h00;
                        end else begin
                            // Wordline stays up through the sense cycle.
                            state <= SENSE;
                            sae   <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                SENSE: begin
                    state            <= RESP;
                    wl_en            <= 1'b0;
                    sae              <= 1'b0;
                    {c8, c4, c2, c1} <= 4'b0000;
                    resp_valid       <= 1'b1;
                    resp_rdata       <= (sram_rdata >> off_q) & mask_q;
                end
                RESP: begin
                    if (resp_ready) begin
                        state      <= IDLE;
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
`ifdef SRAM_ALIGN_CHECK_EN
                        resp_err   <= 1'b0;
`endif
                    end
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_unit_access_ctrl.sv
// Testbench for sram_unit_access_ctrl: table of directed transactions,
// randomized transactions against an arithmetic reference model, and a
// reset-during-access sequence.
module tb_sram_unit_access_ctrl;

    localparam int unsigned ROW_W = 4;
    localparam int unsigned PRE   = 1;
    localparam int unsigned WL    = 2;
`ifdef SRAM_ALIGN_CHECK_EN
    localparam bit ALIGN_ON = 1'b1;
`else
    localparam bit ALIGN_ON = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic             req_valid, req_ready, req_we;
    logic [1:0]       req_size;
    logic [ROW_W+2:0] req_addr;
    logic [7:0]       req_wdata;
    logic             resp_valid, resp_ready;
    logic [7:0]       resp_rdata;
`ifdef SRAM_ALIGN_CHECK_EN
    logic             resp_err;
`endif
    logic [ROW_W-1:0] sram_row;
    logic [2:0]       unit_3_8_dec_sel;
    logic             c8, c4, c2, c1;
    logic             precharge, wl_en, we, sae;
    logic [7:0]       sram_wdata, sram_rdata;

    int checks   = 0;
    int failures = 0;

    sram_unit_access_ctrl #(.ROW_W(ROW_W), .PRE_CYCLES(PRE), .WL_CYCLES(WL)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
`ifdef SRAM_ALIGN_CHECK_EN
        .resp_err(resp_err),
`endif
        .sram_row(sram_row), .unit_3_8_dec_sel(unit_3_8_dec_sel),
        .c8(c8), .c4(c4), .c2(c2), .c1(c1),
        .precharge(precharge), .wl_en(wl_en), .we(we), .sae(sae),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Expected {precharge, wl_en, we, sae} in cycle k after the accept edge (k=1 first).
    function automatic logic [3:0] exp_strobes(input int k, input logic w);
        logic [3:0] s;
        s[3] = (k <= PRE);
        s[2] = (k > PRE);
        s[1] = w && (k > PRE);
        s[0] = !w && (k > PRE + WL);
        return s;
    endfunction

    // Reference model from the access rules using plain arithmetic.
    task automatic model(input logic w, input logic [1:0] size, input logic [6:0] addr,
                         input logic [7:0] wd, input logic [7:0] rd,
                         output logic [2:0] e_sel, output logic [3:0] e_code,
                         output logic [7:0] e_wd, output logic [7:0] e_rd, output logic mis);
        int width, bitidx, idx, off, mask;
        width  = 1 << size;
        bitidx = addr % 8;
        idx    = bitidx / width;
        off    = idx * width;
        mask   = (1 << width) - 1;
        e_sel  = 3'(idx);
        e_code = 4'(1 << size);
        e_wd   = 8'((wd & mask) << off);
        e_rd   = w ? 8'h00 : 8'((rd >> off) & mask);
        mis    = (size == 2'd1 || size == 2'd2) && (bitidx % width != 0);
    endtask

    task automatic do_reset();
        reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
        req_addr = '0; req_wdata = 8'h00; resp_ready = 1'b0; sram_rdata = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // One complete transaction with per-cycle checks; all loops are fixed-length.
    task automatic txn(input logic t_we, input logic [1:0] t_size, input logic [6:0] t_addr,
                       input logic [7:0] t_wd, input logic [7:0] t_rd, input int hold,
                       input logic [2:0] e_sel, input logic [3:0] e_code,
                       input logic [7:0] e_wd, input logic [7:0] e_rd, input logic e_err);
        int lat;
        @(negedge clk);
        chk("idle_req_ready", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_we = t_we; req_size = t_size; req_addr = t_addr;
        req_wdata = t_wd; sram_rdata = t_rd; resp_ready = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_wdata = 8'($urandom);
        lat = e_err ? 1 : int'(PRE + WL) + (t_we ? 1 : 2);
        for (int k = 1; k < lat; k++) begin
            chk("strobes", 32'({precharge, wl_en, we, sae}), 32'(exp_strobes(k, t_we)));
            chk("width_code", 32'({c8, c4, c2, c1}), 32'(e_code));
            chk("dec_sel", 32'(unit_3_8_dec_sel), 32'(e_sel));
            chk("sram_row", 32'(sram_row), 32'(t_addr >> 3));
            if (t_we) chk("sram_wdata", 32'(sram_wdata), 32'(e_wd));
            chk("busy_ready_valid", 32'({req_ready, resp_valid}), 32'd0);
            @(posedge clk); #1;
        end
        for (int h = 0; h <= hold; h++) begin
            chk("resp_valid", 32'(resp_valid), 32'd1);
            chk("resp_rdata", 32'(resp_rdata), 32'(e_rd));
            chk("resp_strobes_code", 32'({precharge, wl_en, we, sae, c8, c4, c2, c1}), 32'd0);
            chk("resp_req_ready", 32'(req_ready), 32'd0);
`ifdef SRAM_ALIGN_CHECK_EN
            chk("resp_err", 32'(resp_err), 32'(e_err));
`endif
            if (h == hold) resp_ready = 1'b1;
            @(posedge clk); #1;
        end
        resp_ready = 1'b0;
        chk("retire", 32'({resp_valid, req_ready}), 32'b01);
    endtask

    typedef struct {
        logic       we;
        logic [1:0] size;
        logic [6:0] addr;
        logic [7:0] wd;
        logic [7:0] rd;
        int         hold;
        logic [2:0] sel;
        logic [3:0] code;
        logic [7:0] ewd;
        logic [7:0] erd;
    } vec_t;

    vec_t vt[9];

    initial begin
        logic [2:0] m_sel;
        logic [3:0] m_code;
        logic [7:0] m_wd, m_rd;
        logic       m_mis;
        logic       r_we;
        logic [1:0] r_size;
        logic [6:0] r_addr;
        logic [7:0] r_wd, r_rd;

        vt[0] = '{1'b1, 2'd0, 7'h1D, 8'h01, 8'h00, 0, 3'd5, 4'b0001, 8'h20, 8'h00};
        vt[1] = '{1'b0, 2'd2, 7'h4C, 8'h00, 8'hA5, 0, 3'd1, 4'b0100, 8'h00, 8'h0A};
        vt[2] = '{1'b0, 2'd3, 7'h78, 8'h00, 8'h3C, 3, 3'd0, 4'b1000, 8'h00, 8'h3C};
        vt[3] = '{1'b1, 2'd1, 7'h16, 8'hFE, 8'h00, 1, 3'd3, 4'b0010, 8'h80, 8'h00};
        vt[4] = '{1'b1, 2'd2, 7'h28, 8'hAB, 8'h00, 0, 3'd0, 4'b0100, 8'h0B, 8'h00};
        vt[5] = '{1'b0, 2'd0, 7'h0F, 8'h00, 8'h80, 0, 3'd7, 4'b0001, 8'h00, 8'h01};
        vt[6] = '{1'b0, 2'd1, 7'h32, 8'h00, 8'hC6, 2, 3'd1, 4'b0010, 8'h00, 8'h01};
        vt[7] = '{1'b1, 2'd3, 7'h50, 8'h5A, 8'h00, 0, 3'd0, 4'b1000, 8'h5A, 8'h00};
        vt[8] = '{1'b0, 2'd1, 7'h23, 8'h00, 8'h08, 0, 3'd1, 4'b0010, 8'h00, 8'h02};

        do_reset();
        // Reset state
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_outputs", 32'({resp_valid, precharge, wl_en, we, sae, c8, c4, c2, c1}), 32'd0);
        chk("rst_data", 32'({resp_rdata, sram_wdata, sram_row, unit_3_8_dec_sel}), 32'd0);

        // Directed table
        for (int i = 0; i < 9; i++) begin
            model(vt[i].we, vt[i].size, vt[i].addr, vt[i].wd, vt[i].rd,
                  m_sel, m_code, m_wd, m_rd, m_mis);
            if (!(ALIGN_ON && m_mis))
                txn(vt[i].we, vt[i].size, vt[i].addr, vt[i].wd, vt[i].rd, vt[i].hold,
                    vt[i].sel, vt[i].code, vt[i].ewd, vt[i].erd, 1'b0);
        end

        // Randomized transactions against the reference model
        for (int i = 0; i < 60; i++) begin
            r_we   = 1'($urandom);
            r_size = 2'($urandom);
            r_addr = 7'($urandom);
            r_wd   = 8'($urandom);
            r_rd   = 8'($urandom);
            model(r_we, r_size, r_addr, r_wd, r_rd, m_sel, m_code, m_wd, m_rd, m_mis);
            if (ALIGN_ON && m_mis) m_rd = 8'h00;
            txn(r_we, r_size, r_addr, r_wd, r_rd, int'($urandom_range(0, 2)),
                m_sel, m_code, m_wd, m_rd, ALIGN_ON && m_mis);
        end

`ifdef SRAM_ALIGN_CHECK_EN
        // Misaligned 2b access goes straight to an error response
        txn(1'b0, 2'd1, 7'h0B, 8'h00, 8'hFF, 0, 3'd0, 4'b0000, 8'h00, 8'h00, 1'b1);
`endif

        // Reset in the middle of the wordline phase of a write
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_addr = 7'h1D; req_wdata = 8'h01;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (PRE) @(posedge clk);
        #1;
        chk("pre_reset_wl_we", 32'({wl_en, we}), 32'b11);
        #2;
        reset = 1'b1;
        #1;
        chk("reset_strobes", 32'({precharge, wl_en, we, sae}), 32'd0);
        chk("reset_code", 32'({c8, c4, c2, c1}), 32'd0);
        chk("reset_ready_valid", 32'({req_ready, resp_valid}), 32'b10);
        @(negedge clk);
        reset = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            chk("no_resp_after_reset", 32'({resp_valid, wl_en, we, req_ready}), 32'b0001);
        end

        // Controller still works after the aborted access
        txn(1'b0, 2'd2, 7'h4C, 8'h00, 8'hA5, 0, 3'd1, 4'b0100, 8'h00, 8'h0A, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
